// File: rtl/operand_fifo_if.sv
// Handshake bundle between the accumulator (push side), operand_fifo and the
// execute stage (out side).
interface operand_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          push;
  logic [1:0]    push_cnt;
  logic [7:0]    push_b0;
  logic [7:0]    push_b1;
  logic [7:0]    push_b2;
  logic          full;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_cnt;
  logic [7:0]    out_b0;
  logic [7:0]    out_b1;
  logic [7:0]    out_b2;
  logic [LW-1:0] level;
  logic          overflow;
  logic          ovf_clr;

  modport master (
    output push, push_cnt, push_b0, push_b1, push_b2, out_ready, ovf_clr,
    input  full, out_valid, out_cnt, out_b0, out_b1, out_b2, level, overflow
  );

  modport slave (
    input  push, push_cnt, push_b0, push_b1, push_b2, out_ready, ovf_clr,
    output full, out_valid, out_cnt, out_b0, out_b1, out_b2, level, overflow
  );
endinterface

// File: rtl/operand_fifo.sv
// Group FIFO between accumulator and execute stage; keeps byte count plus up to
// three bytes per entry. Define OPFIFO_BYPASS_EN for same-cycle pass-through when empty.
module operand_fifo #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  operand_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [1:0] cnt;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] lvl;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full_w;
  logic          push_vld;
  logic          bypass;
  logic          out_valid_w;
  logic          pop;
  logic          accept;
  logic          wr_en;
  logic          rd_en;
  logic          lost;
  logic          overflow_q;
  entry_t        push_e;
  entry_t        head_e;
  entry_t        out_e;

  // Bytes beyond the group's count are stored as zero, never copied from the inputs.
  function automatic entry_t mask_group(input logic [1:0] cnt, input logic [7:0] b0,
                                        input logic [7:0] b1, input logic [7:0] b2);
    entry_t e;
    e.cnt = cnt;
    e.b0  = (cnt >= 2'd1) ? b0 : 8'h00;
    e.b1  = (cnt >= 2'd2) ? b1 : 8'h00;
    e.b2  = (cnt == 2'd3) ? b2 : 8'h00;
    return e;
  endfunction

  assign wr_idx   = wr_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign empty    = (wr_ptr == rd_ptr);
  assign full_w   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign lvl      = wr_ptr - rd_ptr;
  assign push_vld = bus.push && (bus.push_cnt != 2'd0);
  assign push_e   = mask_group(bus.push_cnt, bus.push_b0, bus.push_b1, bus.push_b2);
  assign head_e   = mem[rd_idx];

`ifdef OPFIFO_BYPASS_EN
  assign bypass = empty && push_vld;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid_w = 1'b0;
    out_e       = '0;
    if (bypass) begin
      out_valid_w = 1'b1;
      out_e       = push_e;
    end else if (!empty) begin
      out_valid_w = 1'b1;
      out_e       = head_e;
    end
  end

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign pop    = out_valid_w && bus.out_ready;
  assign accept = push_vld && (!full_w || pop);
  assign wr_en  = accept && !(bypass && bus.out_ready);
  assign rd_en  = pop && !empty;
  assign lost   = push_vld && full_w && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (lost)             overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_e;
  end

  assign bus.full      = full_w;
  assign bus.level     = lvl;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_w;
  assign bus.out_cnt   = out_e.cnt;
  assign bus.out_b0    = out_e.b0;
  assign bus.out_b1    = out_e.b1;
  assign bus.out_b2    = out_e.b2;
endmodule

// File: tb/tb_operand_fifo.sv
// Scoreboard bench for operand_fifo: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_operand_fifo;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   mon_en;
  int   m_level;
  bit   m_ovf;
  logic [25:0] exp_q[$];

  operand_fifo_if #(.DEPTH(DEPTH)) bus ();

  operand_fifo #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [25:0] model_group(int c, logic [7:0] x0, logic [7:0] x1, logic [7:0] x2);
    logic [7:0] bs [3];
    bs[0] = x0; bs[1] = x1; bs[2] = x2;
    for (int i = 0; i < 3; i++) if (i >= c) bs[i] = 8'h00;
    return {c[1:0], bs[0], bs[1], bs[2]};
  endfunction

  // Drive one cycle at posedge+1, predict its effect, return at next posedge+1.
  task automatic step(input bit p, input int c, input logic [7:0] x0, input logic [7:0] x1,
                      input logic [7:0] x2, input bit rdy, input bit clr);
    bit pv, pop, acc, head;
    int lvl_nx;
    bit ovf_nx;
    bus.push = p; bus.push_cnt = c[1:0];
    bus.push_b0 = x0; bus.push_b1 = x1; bus.push_b2 = x2;
    bus.out_ready = rdy; bus.ovf_clr = clr;
    pv   = p && (c != 0);
    head = (m_level != 0);
`ifdef OPFIFO_BYPASS_EN
    if (pv) head = 1'b1;
`endif
    pop = head && rdy;
    acc = pv && ((m_level < DEPTH) || pop);
    if (acc) exp_q.push_back(model_group(c, x0, x1, x2));
    lvl_nx = m_level + int'(acc) - int'(pop);
    if (pv && m_level == DEPTH && !pop) ovf_nx = 1'b1;
    else if (clr)                       ovf_nx = 1'b0;
    else                                ovf_nx = m_ovf;
    @(posedge clk);
    #1;
    m_level = lvl_nx;
    m_ovf   = ovf_nx;
  endtask

  task automatic idle(input bit rdy, input bit clr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 8'h00, 8'h00, 8'h00, rdy, clr);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_level"}, {29'd0, bus.level}, 32'd0);
    chk({tag, "_full"}, {31'd0, bus.full}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, bus.overflow}, 32'd0);
    chk({tag, "_data"}, {6'd0, bus.out_cnt, bus.out_b0, bus.out_b1, bus.out_b2}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_v;
      exp_v = (m_level != 0);
`ifdef OPFIFO_BYPASS_EN
      if (bus.push && bus.push_cnt != 2'd0) exp_v = 1'b1;
`endif
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_v});
      chk("level", {29'd0, bus.level}, m_level);
      chk("full", {31'd0, bus.full}, {31'd0, (m_level == DEPTH)});
      chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("head_unexpected", {6'd0, bus.out_cnt, bus.out_b0, bus.out_b1, bus.out_b2}, 32'hFFFF_FFFF);
        end else begin
          chk("head", {6'd0, bus.out_cnt, bus.out_b0, bus.out_b1, bus.out_b2}, {6'd0, exp_q[0]});
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_zero", {6'd0, bus.out_cnt, bus.out_b0, bus.out_b1, bus.out_b2}, 32'd0);
      end
    end
  end

  initial begin
    total = 0; bad = 0; mon_en = 1'b0; m_level = 0; m_ovf = 1'b0;
    rst_n = 1'b0;
    bus.push = 1'b1; bus.push_cnt = 2'd2;
    bus.push_b0 = 8'h11; bus.push_b1 = 8'h22; bus.push_b2 = 8'h99;
    bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("rst");

    // First group after reset, masked third byte
    rst_n = 1'b1; mon_en = 1'b1;
    step(1'b1, 2, 8'h11, 8'h22, 8'h99, 1'b0, 1'b0);
    chk("tp1_cnt", {30'd0, bus.out_cnt}, 32'd2);
    chk("tp1_b0", {24'd0, bus.out_b0}, 32'h11);
    chk("tp1_b2", {24'd0, bus.out_b2}, 32'h00);
    idle(1'b1, 1'b0, 2);

    // Fill and overflow
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1 + (i % 3), 8'h21 + 8'(i), 8'h31 + 8'(i), 8'h41 + 8'(i), 1'b0, 1'b0);
      if (i == 3) begin
        chk("fill_full", {31'd0, bus.full}, 32'd1);
        chk("fill_level", {29'd0, bus.level}, 32'd4);
      end
    end
    chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
    chk("ovf_head", {24'd0, bus.out_b0}, 32'h21);

    // Clear, then push and pop together on a full FIFO
    idle(1'b0, 1'b1, 1);
    chk("ovf_clr", {31'd0, bus.overflow}, 32'd0);
    step(1'b1, 3, 8'h5A, 8'h5B, 8'h5C, 1'b1, 1'b0);
    chk("pp_level", {29'd0, bus.level}, 32'd4);
    chk("pp_full", {31'd0, bus.full}, 32'd1);
    chk("pp_ovf", {31'd0, bus.overflow}, 32'd0);
    idle(1'b1, 1'b0, 5);

    // Streaming 1..10 across pointer wrap
    for (int i = 1; i <= 10; i++) step(1'b1, 1, 8'(i), 8'hEE, 8'hEE, 1'b1, 1'b0);
    idle(1'b1, 1'b0, 2);

    // cnt=0 is ignored; overflow set beats a same-cycle clear
    step(1'b1, 0, 8'h77, 8'h77, 8'h77, 1'b0, 1'b0);
    chk("cnt0_level", {29'd0, bus.level}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 2, 8'h60 + 8'(i), 8'h70, 8'h80, 1'b0, 1'b0);
    step(1'b1, 1, 8'h99, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("ovf_set_wins", {31'd0, bus.overflow}, 32'd1);
    step(1'b1, 0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    chk("cnt0_full_ovf", {31'd0, bus.overflow}, 32'd1);
    idle(1'b1, 1'b1, 5);

`ifdef OPFIFO_BYPASS_EN
    step(1'b1, 3, 8'hA1, 8'hB2, 8'hC3, 1'b1, 1'b0);
    chk("byp_level", {29'd0, bus.level}, 32'd0);
    step(1'b1, 1, 8'hD4, 8'hE5, 8'hF6, 1'b0, 1'b0);
    chk("byp_hold_level", {29'd0, bus.level}, 32'd1);
    idle(1'b1, 1'b0, 2);
`endif

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 3, 8'hC0 + 8'(i), 8'hC8, 8'hCF, 1'b0, 1'b0);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete(); m_level = 0; m_ovf = 1'b0;
    bus.push = 1'b0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    step(1'b1, 1, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("postrst_level", {29'd0, bus.level}, 32'd1);
    idle(1'b1, 1'b0, 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit p, rdy, clr;
      p   = ($urandom_range(0, 3) != 0);
      rdy = (i % 64 < 40) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 9) == 0);
      step(p, $urandom_range(0, 3), 8'($urandom), 8'($urandom), 8'($urandom), rdy, clr);
    end
    idle(1'b1, 1'b0, DEPTH + 2);
    chk("drain_empty", exp_q.size(), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_fifo.md
# operand_fifo

Buffers byte groups of one to three bytes that the accumulator stage publishes, and hands them one group at a time to the execute stage over a valid/ready handshake. It sits directly downstream of the accumulator. The upstream side is push-only with no back-pressure. Every accepted group is kept intact: byte count plus up to three bytes. The block absorbs bursts while the consumer stalls and flags any loss.

## Interface
- DEPTH, 4, number of group entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- push  in  1  offer one group this cycle
- push_cnt  in  2  valid bytes in the group, 1..3; 0 means no group
- push_b0, push_b1, push_b2  in  8 each  group bytes, b0 first
- full  out  1  all DEPTH entries occupied
- out_valid  out  1  head group present on out_*
- out_ready  in  1  consumer takes the head group when out_valid is high
- out_cnt  out  2  head byte count; 0 when out_valid is low
- out_b0, out_b1, out_b2  out  8 each  head bytes
- level  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
- overflow  out  1  sticky flag; set when a group is lost
- ovf_clr  in  1  clears overflow

## Operation
- Entry format: {cnt[1:0], b0, b1, b2}.
  - Bytes at index ≥ cnt are written as 0x00 and not copied from the inputs.
  - Example: cnt=1 stores b1=b2=0.
- Pointers: wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits, with the MSB used as the wrap bit.
  - Empty: the pointers are equal.
  - Full: the index bits are equal and the MSBs differ.
  - Index wrap-around from DEPTH-1 to 0 is natural.
- Push is valid when push=1 and push_cnt≠0.
  - A valid push is accepted if not full, or if the FIFO is full and a pop happens in the same cycle.
  - Accepting a push writes the entry at wr_ptr and increments wr_ptr.
- A pop happens when out_valid and out_ready are both high; rd_ptr increments.
- Simultaneous push and pop: level is unchanged. On full, the freed slot takes the new group.
- Lost group: a valid push while full with no pop.
  - The group is discarded, storage is unchanged, and overflow is set.
- overflow clears on ovf_clr. If a set and ovf_clr occur in the same cycle, set wins.
- push=1 with push_cnt=0 is ignored: no write, and overflow is not affected.
- out_* shows the entry at rd_ptr. When empty, out_cnt and out_b* are 0.
- level = wr_ptr − rd_ptr (modulo 2^(ptr width)). full = (level==DEPTH).

## Timing
- Reset (asynchronous, takes effect immediately on rst_n low):
  - Pointers 0, level 0, full 0, out_valid 0, out_cnt 0, out_b* 0, overflow 0.
  - Storage contents are don't-care.
- Reset asserted mid-operation drops all stored groups. The first push after release behaves as on an empty FIFO.
- Push-to-output latency is 1 cycle: a group pushed at edge N appears on out_* after edge N, i.e. in cycle N+1.
- Outputs depend only on registered state (apart from the bypass below). out_ready never combinationally affects out_*.
- full and level update on the same edge as the push or pop that changes them.
- At most one push and one pop per cycle.

## Configuration
- OPFIFO_BYPASS_EN defined: when the FIFO is empty and a valid push arrives, the group passes through in the same cycle.
  - out_valid=1 and out_cnt/out_b* take the push values, with masking applied.
  - If out_ready=1 in that cycle, the group is consumed: no write, and level stays 0.
  - If out_ready=0, the group is written normally and stays at the head.
- OPFIFO_BYPASS_EN undefined: there is no combinational path from push_* to out_*. Latency is always 1 cycle as above.

## Test plan
- Reset with push held high → all outputs 0. After rst_n rises, push cnt=2 bytes {0x11,0x22,0x99} → next cycle out_valid=1, out_cnt=2, out_b0=0x11, out_b1=0x22, out_b2=0x00.
- DEPTH=4, out_ready=0, five valid pushes → full=1 and level=4 after the fourth push. The fifth push sets overflow=1, and the head group is still the first.
- Full FIFO with push and pop in the same cycle → level stays 4, full=1, overflow stays 0. The new group comes out after the three older ones.
- Ten push/pop cycles through DEPTH=4 with values 0x01..0x0A → the outputs are exactly 0x01..0x0A in order, across pointer wrap.
- Push with cnt=0 → level unchanged, overflow unchanged. ovf_clr in the same cycle as an overflow event → overflow=1.
- With OPFIFO_BYPASS_EN defined: empty FIFO, push cnt=3 {0xA1,0xB2,0xC3} with out_ready=1 → out_valid=1 with those bytes in the same cycle, and level remains 0.
